decode_port_arbiter: RTL and testbench
======================================

Name: decode_port_arbiter

Overview:
- Round-robin arbiter that shares one 6-bit index → 64-line one-hot select port among NUM_REQ requesters, e.g. register-file wordline select or peripheral chip-select.
- Each requester presents a 6-bit index with a valid/ready handshake.
- The block picks one winner per cycle, decodes its index, and holds the result in an output register with downstream backpressure.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDX_W, 6, index width; fixed at 6. Any other value is a compile-time error.
- OWN_W, $clog2(NUM_REQ), owner-ID width (derived localparam, not overridable).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_idx  in  NUM_REQ*6  packed indices; requester i uses bits [6i+5:6i].
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- sel_valid  out  1  output register holds a decoded select.
- sel_ready  in  1  consumer accepts the current select.
- sel_onehot  out  64  decoded select; bit req_idx[winner] set.
- sel_idx  out  6  raw index of the held select.
- sel_owner  out  OWN_W  requester ID of the held select.

Behaviour:
- Reset (async assert, sync release): sel_valid=0, sel_onehot=0, sel_idx=0, sel_owner=0, rr_ptr=0, lock state cleared.
- Load condition: load = !sel_valid | sel_ready.
  - Arbitration runs every cycle.
  - A grant is issued only when load is true and any req_valid bit is set.
- Winner selection:
  - Winner = first asserted req_valid scanning upward from rr_ptr, wrapping at NUM_REQ-1 → 0.
  - req_ready[winner]=1 in that same cycle; all other req_ready bits are 0.
  - req_ready is 0 for all requesters when load is false.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters must hold req_valid and req_idx stable until accepted.
  - req_ready has no dependency on req_idx.
- On a grant edge:
  - sel_valid←1.
  - sel_idx←req_idx[winner].
  - sel_onehot←1<<req_idx[winner].
  - sel_owner←winner.
  - rr_ptr←(winner+1) mod NUM_REQ.
- Latency: 1 cycle from accepted request to sel_valid.
- Throughput: 1 select/cycle while sel_ready stays high.
- Consumer side:
  - sel_valid&sel_ready with no new grant: sel_valid←0 and sel_onehot←0 on the next edge. sel_idx and sel_owner keep their last values.
  - sel_valid & !sel_ready: all sel_* outputs hold, req_ready=0, rr_ptr holds.
- Simultaneous release and new grant: the new select replaces the old one on the same edge, with no bubble.
- Invariant: sel_onehot is exactly one-hot when sel_valid=1, and all-zero otherwise.
- Reset asserted mid-transfer: the held select is discarded and no req_ready is asserted while rst_n=0.
- A requester that deasserts req_valid before acceptance is not granted; no error is flagged.

Optional Feature:
- Macro: DECODE_PORT_ARB_LOCK_EN.
- Defined:
  - Adds input port req_lock (NUM_REQ bits).
  - If the accepted winner has req_lock[winner]=1, the arbiter enters LOCKED with lock_owner=winner.
  - While LOCKED, only lock_owner can be granted and rr_ptr does not advance.
  - LOCKED exits on the first accepted transfer from lock_owner with req_lock=0; rr_ptr then advances past lock_owner.
  - States: IDLE_RR → LOCKED → IDLE_RR.
  - Reset returns to IDLE_RR.
- Undefined: no req_lock port; pure round-robin.

Decomposition:
- Package decode_port_arb_pkg:
  - IDX_W=6 and SEL_W=64 constants.
  - lock-state enum (ARB_RR, ARB_LOCKED).
  - function onehot6(idx) returning 64 bits.
- Sub-module rr_pick:
  - Combinational rotate-priority picker.
  - Inputs: valid vector, pointer.
  - Outputs: one-hot grant, binary winner ID, any-valid.

Test Plan:
- Reset: rst_n low mid-run with sel_valid=1 → all sel_* zero immediately; after release with req_valid[2]=1, idx=6'd63 → next cycle sel_onehot=1<<63, sel_owner=2.
- Fairness: all 4 requesters valid continuously, sel_ready=1 → owners 0,1,2,3,0… one per cycle; indices 5,17,40,0 give sel_onehot bits 5,17,40,0 in that order.
- Backpressure: sel_ready=0 for 3 cycles with req 1 pending → req_ready=0 and sel_* stable throughout; sel_ready=1 → req 1 accepted the same cycle, sel_owner=1 on the next edge.
- Back-to-back: sel_valid&sel_ready and req_valid[3] in the same cycle → sel replaced with no bubble; with no requests pending → sel_valid=0 and sel_onehot=0.
- Wrap: rr_ptr=3, valid={0,1} only → requester 0 wins, then rr_ptr=1; next cycle requester 1 wins.
- Lock (DECODE_PORT_ARB_LOCK_EN): req 2 locks with all requesters valid → only owner 2 granted for 4 transfers; release with req_lock[2]=0 → next owner 3.

Source files
------------

// File: rtl/decode_port_arbiter_pkg.sv
// Shared constants, lock-state encoding and index decoder for decode_port_arbiter.
package decode_port_arb_pkg;

    localparam int unsigned IDX_W = 6;
    localparam int unsigned SEL_W = 64;

    typedef enum logic [0:0] {
        ARB_RR,
        ARB_LOCKED
    } arb_state_e;

    // 6-bit index to 64-line one-hot select.
    function automatic logic [SEL_W-1:0] onehot6(input logic [IDX_W-1:0] idx);
        logic [SEL_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decode_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first valid bit at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] winner,
    output logic         any
);

    logic [W-1:0] pos;

    // Scan N positions starting at ptr; the first valid one wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = W'((32'(ptr) + k) % N);
            if (!any && valid[pos]) begin
                any         = 1'b1;
                winner      = pos;
                grant[pos]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_port_arbiter.sv
// Round-robin arbiter sharing one 6-bit index -> 64-line one-hot select port.
// Optional lock feature enabled by defining DECODE_PORT_ARB_LOCK_EN.
module decode_port_arbiter
    import decode_port_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 6,
    localparam int unsigned OWN_W  = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
`ifdef DECODE_PORT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     sel_valid,
    input  logic                     sel_ready,
    output logic [63:0]              sel_onehot,
    output logic [IDX_W-1:0]         sel_idx,
    output logic [OWN_W-1:0]         sel_owner
);

    if (IDX_W != 6) begin : g_bad_idx_w
        $error("decode_port_arbiter: IDX_W must be 6");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("decode_port_arbiter: NUM_REQ must be 2..8");
    end

    logic               load;
    logic               any;
    logic               do_grant;
    logic [NUM_REQ-1:0] pick_valid;
    logic [NUM_REQ-1:0] pick_grant;
    logic [OWN_W-1:0]   winner;
    logic [OWN_W-1:0]   ptr_q;
    logic [OWN_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   win_idx;

    assign load = !sel_valid || sel_ready;

`ifdef DECODE_PORT_ARB_LOCK_EN
    arb_state_e         state_q, state_d;
    logic [OWN_W-1:0]   lock_owner_q, lock_owner_d;
    logic [NUM_REQ-1:0] owner_mask;

    // While locked, only the lock owner is eligible.
    always_comb begin
        owner_mask               = '0;
        owner_mask[lock_owner_q] = 1'b1;
        pick_valid = (state_q == ARB_LOCKED) ? (req_valid & owner_mask) : req_valid;
    end

    // Lock FSM next state: enter on a locked grant, leave on the owner's unlocked grant.
    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        if (do_grant) begin
            unique case (state_q)
                ARB_RR: begin
                    if (req_lock[winner]) begin
                        state_d      = ARB_LOCKED;
                        lock_owner_d = winner;
                    end
                end
                ARB_LOCKED: begin
                    if (!req_lock[winner]) state_d = ARB_RR;
                end
                default: state_d = ARB_RR;
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_RR;
            lock_owner_q <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    assign pick_valid = req_valid;
`endif

    rr_pick #(
        .N (NUM_REQ),
        .W (OWN_W)
    ) u_pick (
        .valid  (pick_valid),
        .ptr    (ptr_q),
        .grant  (pick_grant),
        .winner (winner),
        .any    (any)
    );

    // Grant path; rst_n gating keeps req_ready low throughout reset.
    always_comb begin
        do_grant  = load && any && rst_n;
        req_ready = do_grant ? pick_grant : '0;
        win_idx   = req_idx[winner*IDX_W +: IDX_W];
        ptr_nxt   = (winner == OWN_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // Output register and round-robin pointer; a new grant overrides a release.
    // While locked the winner is always the owner, so the pointer stays at owner+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
            sel_idx    <= '0;
            sel_owner  <= '0;
            ptr_q      <= '0;
        end else if (do_grant) begin
            sel_valid  <= 1'b1;
            sel_onehot <= onehot6(win_idx);
            sel_idx    <= win_idx;
            sel_owner  <= winner;
            ptr_q      <= ptr_nxt;
        end else if (sel_ready) begin
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_decode_port_arbiter.sv
// Self-checking bench for decode_port_arbiter (NUM_REQ=4): directed table,
// reset/lock sequences and a randomized run against a behavioural model.
module tb_decode_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_idx;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic        sel_valid;
    logic        sel_ready;
    logic [63:0] sel_onehot;
    logic [5:0]  sel_idx;
    logic [1:0]  sel_owner;

    int vectors;
    int miscompares;

    decode_port_arbiter #(
        .NUM_REQ (4),
        .IDX_W   (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
`ifdef DECODE_PORT_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .sel_owner  (sel_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic [3:0] xr;
        logic       xsv;
        logic [1:0] xo;
        logic [5:0] xi;
    } vec_t;

    vec_t tbl[17];

    // Fixed indices for the directed phases: req0=5, req1=17, req2=40, req3=0.
    localparam logic [23:0] FIX_IDX = {6'd0, 6'd40, 6'd17, 6'd5};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs at negedge, capture req_ready before the edge, return 1ns after posedge.
    task automatic cycle(input logic [3:0] v, input logic [23:0] idx, input logic rdy,
                         output logic [3:0] rr);
        @(negedge clk);
        req_valid = v;
        req_idx   = idx;
        sel_ready = rdy;
        #1 rr = req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        sel_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_sel(input string tag, input logic sv, input logic [1:0] o,
                           input logic [5:0] i);
        chk({tag, ".sel_valid"}, 64'(sel_valid), 64'(sv));
        chk({tag, ".sel_onehot"}, sel_onehot, sv ? (64'd1 << i) : 64'd0);
        chk({tag, ".sel_idx"}, 64'(sel_idx), 64'(i));
        chk({tag, ".sel_owner"}, 64'(sel_owner), 64'(o));
    endtask

    // Behavioural model state.
    int m_sv, m_idx, m_owner, m_ptr;

    // Winner = valid requester at the smallest circular distance from the pointer.
    function automatic int pick(input logic [3:0] v, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = 4;
        for (int i = 0; i < 4; i++) begin
            d = (i - ptr + 4) % 4;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    initial begin
        logic [3:0]  rr;
        logic [3:0]  pend;
        logic [5:0]  pidx[4];
        logic [23:0] ridx;
        logic        rdy;
        logic [3:0]  xr;
        int          w;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_idx     = '0;
        req_lock    = '0;
        sel_ready   = 1'b0;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 6'd5};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 6'd17};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 6'd40};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 6'd0};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 6'd5};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 6'd5};
        tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 6'd17};
        tbl[7]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 6'd17};
        tbl[8]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 6'd17};
        tbl[9]  = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 6'd17};
        tbl[10] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 6'd17};
        tbl[11] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 6'd0};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 6'd0};
        tbl[13] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 6'd40};
        tbl[14] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 6'd5};
        tbl[15] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 6'd17};
        tbl[16] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 6'd17};

        // Reset values, then reset asserted while a select is held.
        do_reset();
        #1 chk_sel("rst_init", 1'b0, 2'd0, 6'd0);
        cycle(4'b0001, FIX_IDX, 1'b0, rr);
        chk_sel("rst_pre", 1'b1, 2'd0, 6'd5);
        @(negedge clk);
        req_valid = 4'b1111;
        rst_n     = 1'b0;
        #1;
        chk_sel("rst_mid", 1'b0, 2'd0, 6'd0);
        chk("rst_mid.req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_idx   = {6'd0, 6'd63, 6'd17, 6'd5};
        sel_ready = 1'b1;
        #1 chk("rst_rel.req_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1 chk_sel("rst_rel", 1'b1, 2'd2, 6'd63);

        // Directed table: fairness, backpressure, back-to-back, wrap.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cycle(tbl[k].v, FIX_IDX, tbl[k].rdy, rr);
            chk($sformatf("tbl%0d.req_ready", k), 64'(rr), 64'(tbl[k].xr));
            chk_sel($sformatf("tbl%0d", k), tbl[k].xsv, tbl[k].xo, tbl[k].xi);
        end

`ifdef DECODE_PORT_ARB_LOCK_EN
        // Requester 2 locks, holds four transfers, releases, then 3 is next.
        do_reset();
        req_lock = 4'b0100;
        cycle(4'b0100, FIX_IDX, 1'b1, rr);
        chk("lock0.req_ready", 64'(rr), 64'b0100);
        for (int k = 1; k < 4; k++) begin
            cycle(4'b1111, FIX_IDX, 1'b1, rr);
            chk($sformatf("lock%0d.req_ready", k), 64'(rr), 64'b0100);
            chk($sformatf("lock%0d.owner", k), 64'(sel_owner), 64'd2);
        end
        req_lock = 4'b0000;
        cycle(4'b1111, FIX_IDX, 1'b1, rr);
        chk("unlock.req_ready", 64'(rr), 64'b0100);
        cycle(4'b1111, FIX_IDX, 1'b1, rr);
        chk("after_unlock.req_ready", 64'(rr), 64'b1000);
        chk("after_unlock.owner", 64'(sel_owner), 64'd3);
`endif

        // Randomized run against the model.
        do_reset();
        m_sv = 0; m_idx = 0; m_owner = 0; m_ptr = 0;
        pend = '0;
        for (int i = 0; i < 4; i++) pidx[i] = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i] = 1'b1;
                    pidx[i] = 6'($urandom_range(63, 0));
                end else if (pend[i] && ($urandom % 8 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            ridx = {pidx[3], pidx[2], pidx[1], pidx[0]};
            rdy  = 1'($urandom % 4 != 0);
            xr   = '0;
            w    = (m_sv == 0 || rdy) ? pick(pend, m_ptr) : -1;
            if (w >= 0) xr[w] = 1'b1;
            cycle(pend, ridx, rdy, rr);
            if (w >= 0) begin
                m_sv    = 1;
                m_idx   = int'(pidx[w]);
                m_owner = w;
                m_ptr   = (w + 1) % 4;
                pend[w] = 1'b0;
            end else if (rdy) begin
                m_sv = 0;
            end
            chk($sformatf("rnd%0d.req_ready", c), 64'(rr), 64'(xr));
            chk_sel($sformatf("rnd%0d", c), 1'(m_sv), 2'(m_owner), 6'(m_idx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
